// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS control path: opcode constants,
// ALUOp encodings (also imported by the ALU control decoder), the main
// control state encoding and the bundle of datapath control signals.
package mips_ctrl_pkg;

  // Instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALUOp encodings seen by the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // State codes are visible on the debug display, so the values are fixed.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_RTCOMP = 4'd8,
    ST_BEQ    = 4'd9,
    ST_JUMP   = 4'd10,
    ST_ADDIEX = 4'd11,
    ST_ADDIWB = 4'd12
  } state_e;

  // Unqualified control values for one state. Strobes in here are not yet
  // gated by the step enable; retire marks the last state of an instruction.
  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       irWrite;
    logic [1:0] pcSource;
    logic [1:0] aluOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       regWrite;
    logic       regDst;
    logic       retire;
  } ctrl_t;

endpackage

// File: rtl/mcc_output_decode.sv
// mcc_output_decode
// Purely combinational state-to-control table for the multicycle main control.
// Ports:
//   state_i : current state of the main control FSM
//   ctrl_o  : control values for that state (write strobes not yet step-gated)
module mcc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      ST_FETCH: begin
        ctrl_o.memRead  = 1'b1;
        ctrl_o.irWrite  = 1'b1;
        ctrl_o.aluSrcB  = 2'b01;
        ctrl_o.aluOp    = ALUOP_ADD;
        ctrl_o.pcWrite  = 1'b1;
        ctrl_o.pcSource = 2'b00;
      end
      ST_DECODE: begin
        ctrl_o.aluSrcB = 2'b11;
        ctrl_o.aluOp   = ALUOP_ADD;
      end
      ST_MEMADR, ST_ADDIEX: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = 2'b10;
        ctrl_o.aluOp   = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl_o.memRead = 1'b1;
        ctrl_o.iorD    = 1'b1;
      end
      ST_MEMWB: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.memtoReg = 1'b1;
        ctrl_o.regDst   = 1'b0;
        ctrl_o.retire   = 1'b1;
      end
      ST_MEMWR: begin
        ctrl_o.memWrite = 1'b1;
        ctrl_o.iorD     = 1'b1;
        ctrl_o.retire   = 1'b1;
      end
      ST_EXEC: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = 2'b00;
        ctrl_o.aluOp   = ALUOP_FUNCT;
      end
      ST_RTCOMP: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.regDst   = 1'b1;
        ctrl_o.retire   = 1'b1;
      end
      ST_BEQ: begin
        ctrl_o.aluSrcA     = 1'b1;
        ctrl_o.aluOp       = ALUOP_SUB;
        ctrl_o.pcWriteCond = 1'b1;
        ctrl_o.pcSource    = 2'b01;
        ctrl_o.retire      = 1'b1;
      end
      ST_JUMP: begin
        ctrl_o.pcWrite  = 1'b1;
        ctrl_o.pcSource = 2'b10;
        ctrl_o.retire   = 1'b1;
      end
      ST_ADDIWB: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.regDst   = 1'b0;
        ctrl_o.retire   = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// multicycle_main_control
// Moore main control FSM for the multicycle MIPS datapath. Steps through
// fetch/decode/execute/memory/writeback one state per enabled cycle so a
// push-button on i_step can single-step the processor.
// Parameters:
//   SUPPORT_J, SUPPORT_ADDI : when 0 the matching opcode is decoded as illegal
// Ports:
//   i_clk, i_rst_n          : clock (rising edge), async active-low reset
//   i_step                  : advance enable
//   i_Opcode                : instruction bits [31:26]
//   o_PCWrite..o_RegDst     : datapath controls (write strobes gated by i_step)
//   o_state                 : current state code for the debug display
//   o_instr_done            : pulse on the enabled cycle an instruction retires
//   o_illegal               : sticky illegal-opcode flag, cleared only by reset
module multicycle_main_control
  import mips_ctrl_pkg::*;
#(
  parameter bit SUPPORT_J    = 1'b1,
  parameter bit SUPPORT_ADDI = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_step,
  input  logic [5:0] i_Opcode,
  output logic       o_PCWrite,
  output logic       o_PCWriteCond,
  output logic       o_IorD,
  output logic       o_MemRead,
  output logic       o_MemWrite,
  output logic       o_MemtoReg,
  output logic       o_IRWrite,
  output logic [1:0] o_PCSource,
  output logic [1:0] o_ALUOp,
  output logic       o_ALUSrcA,
  output logic [1:0] o_ALUSrcB,
  output logic       o_RegWrite,
  output logic       o_RegDst,
  output logic [3:0] o_state,
  output logic       o_instr_done,
  output logic       o_illegal
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  ctrl_t  ctrl;

  // Opcode is only looked at in DECODE and MEMADR; elsewhere the sequence is
  // fixed. Codes 13-15 cannot be reached but recover to FETCH if they are.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    if (i_step) begin
      unique case (state_q)
        ST_IDLE:   state_d = ST_FETCH;
        ST_FETCH:  state_d = ST_DECODE;
        ST_DECODE: begin
          if (i_Opcode == OP_LW || i_Opcode == OP_SW) begin
            state_d = ST_MEMADR;
          end else if (i_Opcode == OP_RTYPE) begin
            state_d = ST_EXEC;
          end else if (i_Opcode == OP_BEQ) begin
            state_d = ST_BEQ;
          end else if (SUPPORT_J && i_Opcode == OP_J) begin
            state_d = ST_JUMP;
          end else if (SUPPORT_ADDI && i_Opcode == OP_ADDI) begin
            state_d = ST_ADDIEX;
          end else begin
            state_d   = ST_FETCH;
            illegal_d = 1'b1;
          end
        end
        ST_MEMADR: state_d = (i_Opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
        ST_MEMRD:  state_d = ST_MEMWB;
        ST_EXEC:   state_d = ST_RTCOMP;
        ST_ADDIEX: state_d = ST_ADDIWB;
        ST_MEMWB, ST_MEMWR, ST_RTCOMP, ST_BEQ, ST_JUMP, ST_ADDIWB:
                   state_d = ST_FETCH;
        default:   state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  mcc_output_decode u_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // Strobes are qualified by i_step so a stalled cycle changes no
  // architectural state, while mux selects and MemRead keep following state.
  assign o_PCWrite     = ctrl.pcWrite & i_step;
  assign o_PCWriteCond = ctrl.pcWriteCond & i_step;
  assign o_IRWrite     = ctrl.irWrite & i_step;
  assign o_MemWrite    = ctrl.memWrite & i_step;
  assign o_RegWrite    = ctrl.regWrite & i_step;
  assign o_IorD        = ctrl.iorD;
  assign o_MemRead     = ctrl.memRead;
  assign o_MemtoReg    = ctrl.memtoReg;
  assign o_PCSource    = ctrl.pcSource;
  assign o_ALUOp       = ctrl.aluOp;
  assign o_ALUSrcA     = ctrl.aluSrcA;
  assign o_ALUSrcB     = ctrl.aluSrcB;
  assign o_RegDst      = ctrl.regDst;
  assign o_state       = state_q;
  assign o_instr_done  = ctrl.retire & i_step;
  assign o_illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control
// Self-checking bench for multicycle_main_control: a directed vector table,
// hand-written reset/illegal sequences, and randomized stepping compared
// against an instruction-level reference model.
module tb_multicycle_main_control;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] BAD  = 6'b111111;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       irWrite;
    logic [1:0] pcSource;
    logic [1:0] aluOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       regWrite;
    logic       regDst;
  } ctrlVec_t;

  typedef struct {
    logic       step;
    logic [5:0] op;
    int         expState;
    logic       expDone;
    logic       expIll;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with all opcodes enabled
  logic       rstN, step;
  logic [5:0] op;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, memtoReg, irWrite;
  logic [1:0] pcSource, aluOp, aluSrcB;
  logic       aluSrcA, regWrite, regDst, instrDone, illegal;
  logic [3:0] state;
  ctrlVec_t   actCtrl;

  // DUT with j disabled
  logic       rst2N, step2;
  logic [5:0] op2;
  logic       pcWrite2, pcWriteCond2, iorD2, memRead2, memWrite2, memtoReg2, irWrite2;
  logic [1:0] pcSource2, aluOp2, aluSrcB2;
  logic       aluSrcA2, regWrite2, regDst2, instrDone2, illegal2;
  logic [3:0] state2;

  int checks = 0;
  int failures = 0;

  vec_t vecs[$];

  // Reference model: current state, sticky illegal, and the remaining
  // states of the instruction in flight.
  int mState;
  bit mIll;
  int mPlan[$];

  multicycle_main_control dut (
    .i_clk(clk), .i_rst_n(rstN), .i_step(step), .i_Opcode(op),
    .o_PCWrite(pcWrite), .o_PCWriteCond(pcWriteCond), .o_IorD(iorD),
    .o_MemRead(memRead), .o_MemWrite(memWrite), .o_MemtoReg(memtoReg),
    .o_IRWrite(irWrite), .o_PCSource(pcSource), .o_ALUOp(aluOp),
    .o_ALUSrcA(aluSrcA), .o_ALUSrcB(aluSrcB), .o_RegWrite(regWrite),
    .o_RegDst(regDst), .o_state(state), .o_instr_done(instrDone),
    .o_illegal(illegal)
  );

  multicycle_main_control #(.SUPPORT_J(1'b0), .SUPPORT_ADDI(1'b1)) dutNoJ (
    .i_clk(clk), .i_rst_n(rst2N), .i_step(step2), .i_Opcode(op2),
    .o_PCWrite(pcWrite2), .o_PCWriteCond(pcWriteCond2), .o_IorD(iorD2),
    .o_MemRead(memRead2), .o_MemWrite(memWrite2), .o_MemtoReg(memtoReg2),
    .o_IRWrite(irWrite2), .o_PCSource(pcSource2), .o_ALUOp(aluOp2),
    .o_ALUSrcA(aluSrcA2), .o_ALUSrcB(aluSrcB2), .o_RegWrite(regWrite2),
    .o_RegDst(regDst2), .o_state(state2), .o_instr_done(instrDone2),
    .o_illegal(illegal2)
  );

  assign actCtrl = '{pcWrite, pcWriteCond, iorD, memRead, memWrite, memtoReg,
                     irWrite, pcSource, aluOp, aluSrcA, aluSrcB, regWrite, regDst};

  // Expected datapath controls for a state code, from the control table.
  function automatic ctrlVec_t expCtrl(input int st, input logic stp);
    ctrlVec_t c;
    c = '0;
    case (st)
      1:  begin c.memRead = 1; c.irWrite = 1; c.aluSrcB = 2'b01; c.pcWrite = 1; end
      2:  c.aluSrcB = 2'b11;
      3, 11: begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
      4:  begin c.memRead = 1; c.iorD = 1; end
      5:  begin c.regWrite = 1; c.memtoReg = 1; end
      6:  begin c.memWrite = 1; c.iorD = 1; end
      7:  begin c.aluSrcA = 1; c.aluOp = 2'b10; end
      8:  begin c.regWrite = 1; c.regDst = 1; end
      9:  begin c.aluSrcA = 1; c.aluOp = 2'b01; c.pcWriteCond = 1; c.pcSource = 2'b01; end
      10: begin c.pcWrite = 1; c.pcSource = 2'b10; end
      12: c.regWrite = 1;
      default: ;
    endcase
    if (!stp) begin
      c.pcWrite = 0; c.pcWriteCond = 0; c.irWrite = 0; c.memWrite = 0; c.regWrite = 0;
    end
    return c;
  endfunction

  task automatic checkEq(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input int expState, input logic stp,
                             input logic expDone, input logic expIll);
    checkEq({name, " state"}, 32'(state), expState);
    checkEq({name, " ctrl"}, 32'(actCtrl), 32'(expCtrl(expState, stp)));
    checkEq({name, " done"}, 32'(instrDone), 32'(expDone));
    checkEq({name, " illegal"}, 32'(illegal), 32'(expIll));
  endtask

  task automatic addVec(input logic s, input logic [5:0] o, input int st,
                        input logic d, input logic il);
    vec_t v;
    v.step = s; v.op = o; v.expState = st; v.expDone = d; v.expIll = il;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic s, input logic [5:0] o);
    step = s;
    op   = o;
  endtask

  // One enabled step of the model: each instruction is a fixed list of
  // phases chosen when it is decoded.
  task automatic modelAdvance(input logic s, input logic [5:0] o);
    if (!s) return;
    case (mState)
      0: mState = 1;
      1: mState = 2;
      2: begin
        mPlan.delete();
        if (o == LW)        mPlan = '{3, 4, 5};
        else if (o == SW)   mPlan = '{3, 6};
        else if (o == RT)   mPlan = '{7, 8};
        else if (o == BEQ)  mPlan = '{9};
        else if (o == JMP)  mPlan = '{10};
        else if (o == ADDI) mPlan = '{11, 12};
        if (mPlan.size() == 0) begin
          mIll   = 1'b1;
          mState = 1;
        end else begin
          mState = mPlan.pop_front();
        end
      end
      default: mState = (mPlan.size() > 0) ? mPlan.pop_front() : 1;
    endcase
  endtask

  function automatic logic [5:0] randomOp();
    case ($urandom_range(0, 7))
      0, 7:    return LW;
      1:       return SW;
      2:       return RT;
      3:       return BEQ;
      4:       return JMP;
      5:       return ADDI;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    // lw from reset, then R-type with a FETCH stall, beq, j, sw with a
    // 3-cycle MEMWR stall, addi, illegal opcode, and a lw after it.
    addVec(1, LW, 0, 0, 0);  addVec(1, LW, 1, 0, 0);  addVec(1, LW, 2, 0, 0);
    addVec(1, LW, 3, 0, 0);  addVec(1, LW, 4, 0, 0);  addVec(1, LW, 5, 1, 0);
    addVec(0, RT, 1, 0, 0);  addVec(1, RT, 1, 0, 0);  addVec(1, RT, 2, 0, 0);
    addVec(1, RT, 7, 0, 0);  addVec(1, RT, 8, 1, 0);
    addVec(1, BEQ, 1, 0, 0); addVec(1, BEQ, 2, 0, 0); addVec(1, BEQ, 9, 1, 0);
    addVec(1, JMP, 1, 0, 0); addVec(1, JMP, 2, 0, 0); addVec(1, JMP, 10, 1, 0);
    addVec(1, SW, 1, 0, 0);  addVec(1, SW, 2, 0, 0);  addVec(1, SW, 3, 0, 0);
    addVec(0, SW, 6, 0, 0);  addVec(0, SW, 6, 0, 0);  addVec(0, SW, 6, 0, 0);
    addVec(1, SW, 6, 1, 0);
    addVec(1, ADDI, 1, 0, 0); addVec(1, ADDI, 2, 0, 0); addVec(1, ADDI, 11, 0, 0);
    addVec(1, ADDI, 12, 1, 0);
    addVec(1, BAD, 1, 0, 0); addVec(0, BAD, 2, 0, 0); addVec(1, BAD, 2, 0, 0);
    addVec(1, LW, 1, 0, 1);  addVec(1, LW, 2, 0, 1);  addVec(1, LW, 3, 0, 1);
    addVec(1, LW, 4, 0, 1);  addVec(1, LW, 5, 1, 1);  addVec(1, LW, 1, 0, 1);

    rstN = 1'b1; rst2N = 1'b1;
    applyStimulus(1'b1, LW);
    step2 = 1'b0; op2 = RT;
    #1 rstN = 1'b0; rst2N = 1'b0;
    repeat (2) @(negedge clk);
    #2 checkOutput("reset", 0, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    rstN = 1'b1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].step, vecs[i].op);
      #2 checkOutput($sformatf("vec%0d", i), vecs[i].expState, vecs[i].step,
                     vecs[i].expDone, vecs[i].expIll);
      @(negedge clk);
    end

    // Asynchronous reset between clock edges while in MEMADR
    applyStimulus(1'b1, LW);
    #2 checkOutput("pre-memadr", 2, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    #2 checkOutput("memadr", 3, 1'b1, 1'b0, 1'b1);
    #1 rstN = 1'b0;
    #1 checkOutput("async-reset", 0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2 checkOutput("reset-held", 0, 1'b1, 1'b0, 1'b0);

    // Randomized stepping against the model
    @(negedge clk);
    rstN = 1'b1;
    mState = 0; mIll = 1'b0; mPlan.delete();
    for (int n = 0; n < 1500; n++) begin
      if (mState != 2 && mState != 3) op = randomOp();
      step = ($urandom_range(0, 3) != 0);
      #2 checkOutput($sformatf("rand%0d", n), mState, step,
                     step && mState > 2 && mPlan.size() == 0, mIll);
      modelAdvance(step, op);
      @(negedge clk);
    end

    // j disabled: opcode 000010 is illegal
    rst2N = 1'b1; step2 = 1'b1; op2 = JMP;
    #2 checkEq("noj state0", 32'(state2), 0);
    @(negedge clk);
    #2 checkEq("noj state1", 32'(state2), 1);
    @(negedge clk);
    #2 checkEq("noj state2", 32'(state2), 2);
    checkEq("noj illegal-before", 32'(illegal2), 0);
    @(negedge clk);
    #2 checkEq("noj state-after", 32'(state2), 1);
    checkEq("noj illegal", 32'(illegal2), 1);
    checkEq("noj done", 32'(instrDone2), 0);
    op2 = LW;
    repeat (5) @(negedge clk);
    #2 checkEq("noj lw-state", 32'(state2), 1);
    checkEq("noj illegal-sticky", 32'(illegal2), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
